// File: rtl/div7_pkg.sv
// Shared types and constants for the divide-by-7 result sweeper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package div7_pkg;

    // Dividend, quotient and remainder widths of the divider under test
    localparam int D_W     = 16;
    localparam int Q_W     = D_W - 2;
    localparam int R_W     = 4;

    // The divider always divides by this constant
    localparam int DIVISOR = 7;

    // Sweep sequencer states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_IDLE  = 3'd1,
        SETUP      = 3'd2,
        PULSE      = 3'd3,
        WAIT_VALID = 3'd4,
        CHECK      = 3'd5,
        DRAIN      = 3'd6,
        FIN        = 3'd7
    } state_t;

endpackage

// File: rtl/div7_sweeper_if.sv
// Request/response bus between the sweeper and a divide-by-7 unit.
// Latency: none (wires only).
// Backpressure: divider signals busy; the requester waits for busy=0 before start.
interface div7_sweeper_if #(
    parameter int D_W = div7_pkg::D_W
) ();
    import div7_pkg::*;

    logic               start;
    logic [D_W-1:0]     data;
    logic               busy;
    logic               valid;
    logic [D_W-3:0]     q;
    logic [R_W-1:0]     reminder;

    // Sweeper side: issues dividends, consumes results
    modport master (
        output start,
        output data,
        input  busy,
        input  valid,
        input  q,
        input  reminder
    );

    // Divider side: accepts dividends, returns results
    modport slave (
        input  start,
        input  data,
        output busy,
        output valid,
        output q,
        output reminder
    );

endinterface

// File: rtl/div7_check.sv
// Combinational check that q*7 + reminder reproduces the dividend with a legal remainder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module div7_check #(
    parameter int D_W = div7_pkg::D_W,
    parameter int Q_W = div7_pkg::Q_W,
    parameter int R_W = div7_pkg::R_W
) (
    input  logic [D_W-1:0] data,
    input  logic [Q_W-1:0] q,
    input  logic [R_W-1:0] reminder,
    output logic           ok
);
    import div7_pkg::*;

    // One extra bit so q*7+r never wraps for any legal quotient
    localparam int S_W = D_W + 1;

    logic [S_W-1:0] prod;
    logic [S_W-1:0] sum;

    // Rebuild the dividend from the result and require remainder < divisor
    always_comb begin
        prod = S_W'(q) * S_W'(DIVISOR);
        sum  = prod + S_W'(reminder);
        ok   = (sum == S_W'(data)) && (reminder < R_W'(DIVISOR));
    end

endmodule

// File: rtl/div7_sweeper.sv
// Walks dividends lo..hi through an external divide-by-7 unit and counts good/bad results.
// Latency: one dividend per ~6 cycles plus divider latency; done one cycle after the last drain.
// Backpressure: waits for busy=0 before each start; aborts the sweep if valid never arrives.
module div7_sweeper #(
    parameter int TIMEOUT_CYC = 300,
    parameter int D_W         = div7_pkg::D_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [D_W-1:0]       lo,
    input  logic [D_W-1:0]       hi,
    div7_sweeper_if.master       div_bus,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [D_W:0]         pass_cnt,
    output logic [D_W:0]         fail_cnt
);
    import div7_pkg::*;

    localparam int QW    = D_W - 2;
    // Wait counter must reach TIMEOUT_CYC+1 to detect the overrun
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);
    localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [D_W-1:0]   DATA_ONE = {{(D_W-1){1'b0}}, 1'b1};
    localparam logic [D_W:0]     TALLY_ONE = {{D_W{1'b0}}, 1'b1};

    state_t             state_q,   state_d;
    logic [D_W-1:0]     data_q,    data_d;
    logic [D_W-1:0]     hi_q,      hi_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [QW-1:0]      q_cap_q,   q_cap_d;
    logic [R_W-1:0]     r_cap_q,   r_cap_d;
    logic [D_W:0]       pass_q,    pass_d;
    logic [D_W:0]       fail_q,    fail_d;
    logic               timeout_q, timeout_d;

    logic               chk_ok;
    logic               drain_clear;
    logic               last_dividend;

    // Divider fully quiet, and whether the current dividend closes the sweep
    assign drain_clear   = !div_bus.valid && !div_bus.busy;
    assign last_dividend = (data_q == hi_q);

    div7_check #(
        .D_W (D_W),
        .Q_W (QW),
        .R_W (R_W)
    ) u_check (
        .data     (data_q),
        .q        (q_cap_q),
        .reminder (r_cap_q),
        .ok       (chk_ok)
    );

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: dividend, bounds, wait counter, captured result, tallies
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q    <= '0;
            hi_q      <= '0;
            cnt_q     <= '0;
            q_cap_q   <= '0;
            r_cap_q   <= '0;
            pass_q    <= '0;
            fail_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            hi_q      <= hi_d;
            cnt_q     <= cnt_d;
            q_cap_q   <= q_cap_d;
            r_cap_q   <= r_cap_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic for the sweep sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = (hi < lo) ? FIN : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!div_bus.busy) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = PULSE;
            end
            PULSE: begin
                state_d = WAIT_VALID;
            end
            WAIT_VALID: begin
                if (div_bus.valid) begin
                    state_d = CHECK;
                end else if (cnt_q > TMO_LIM) begin
                    state_d = FIN;
                end
            end
            CHECK: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_clear) begin
                    state_d = last_dividend ? FIN : WAIT_IDLE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath updates; data_q doubles as the dividend iterator so it stays
    // stable from SETUP through CHECK and only steps in DRAIN
    always_comb begin
        data_d    = data_q;
        hi_d      = hi_q;
        cnt_d     = cnt_q;
        q_cap_d   = q_cap_q;
        r_cap_d   = r_cap_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    data_d    = lo;
                    hi_d      = hi;
                    pass_d    = '0;
                    fail_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            PULSE: begin
                cnt_d = CNT_ONE;
            end
            WAIT_VALID: begin
                if (div_bus.valid) begin
                    q_cap_d = div_bus.q;
                    r_cap_d = div_bus.reminder;
                end else if (cnt_q > TMO_LIM) begin
                    fail_d    = fail_q + TALLY_ONE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CHECK: begin
                if (chk_ok) begin
                    pass_d = pass_q + TALLY_ONE;
                end else begin
                    fail_d = fail_q + TALLY_ONE;
                end
            end
            DRAIN: begin
                // Compare before stepping so hi=all-ones ends without wrapping
                if (drain_clear && !last_dividend) begin
                    data_d = data_q + DATA_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    // Moore outputs decoded from the current state and registers
    always_comb begin
        div_bus.start = (state_q == PULSE);
        div_bus.data  = data_q;
        done          = (state_q == FIN);
        running       = (state_q != IDLE);
        timeout       = timeout_q;
        pass_cnt      = pass_q;
        fail_cnt      = fail_q;
    end

endmodule
